ps2_scancode_rx: RTL

- Parametrised PS/2 keyboard receiver running on the system clock.
- Oversamples and filters the keyboard clock and data lines, deserialises 11-bit frames, and checks odd parity, start bit and stop bit.
- Decodes E0 (extended) and F0 (break) prefixes into flags, then queues complete key events in a show-ahead FIFO for the editor logic.
- Also holds the most recent released key code, which replaces the old keyboard-to-LED path.

---
 rtl/ps2_scancode_rx_if.sv | 24 ++
 rtl/ps2_scancode_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx_if.sv
// Key-event read port of the PS/2 receiver: show-ahead FIFO head plus pop strobe.
interface ps2_scancode_rx_if;
  logic       rd_en;
  logic       code_valid;
  logic [7:0] code;
  logic       code_ext;
  logic       code_break;

  modport master (
    input  rd_en,
    output code_valid,
    output code,
    output code_ext,
    output code_break
  );

  modport slave (
    output rd_en,
    input  code_valid,
    input  code,
    input  code_ext,
    input  code_break
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: conditions the raw lines, deframes 11-bit frames, folds E0/F0
// prefixes into flags and queues key events in a show-ahead FIFO.
module ps2_scancode_rx #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  ps2_scancode_rx_if.master     bus,
  output logic [7:0]            last_break,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overflow
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_s, dat_s;
  logic                   filt_q, filt_prev_q, strobe;
  logic [FW-1:0]          filt_cnt_q;

  state_e                 state_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic                   par_q, done_q;
  logic [TW-1:0]          to_cnt_q;

  logic                   ext_pend_q, brk_pend_q, push_req;

  logic [9:0]             mem [FIFO_DEPTH];
  logic [AW:0]            wptr_q, rptr_q;
  logic [9:0]             hold_q, head, out_entry;
  logic                   empty, full, pop, do_push;

  // Lines idle high, so the synchronisers reset to 1 to avoid a false strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      filt_prev_q <= filt_q;
      if (clk_s != filt_q) begin
        if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
          filt_q     <= clk_s;
          filt_cnt_q <= '0;
        end else begin
          filt_cnt_q <= filt_cnt_q + FW'(1);
        end
      end else begin
        filt_cnt_q <= '0;
      end
    end
  end

  assign strobe = filt_prev_q & ~filt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      done_q     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (state_q == StIdle || strobe) to_cnt_q <= '0;
      else                             to_cnt_q <= to_cnt_q + TW'(1);

      if (state_q != StIdle && !strobe && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        frame_err <= 1'b1;
        state_q   <= StIdle;
      end else if (strobe) begin
        unique case (state_q)
          StIdle: begin
            if (!dat_s) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end
          end
          StData: begin
            shift_q   <= {dat_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= StParity;
          end
          StParity: begin
            par_q   <= dat_s;
            state_q <= StStop;
          end
          StStop: begin
            // Parity failure masks a bad stop bit.
            if (!(^{shift_q, par_q})) parity_err <= 1'b1;
            else if (!dat_s)          frame_err  <= 1'b1;
            else                      done_q     <= 1'b1;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign push_req = done_q && (shift_q != 8'hE0) && (shift_q != 8'hF0);

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      last_break <= '0;
    end else if (parity_err || frame_err) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else if (done_q) begin
      if (shift_q == 8'hE0) begin
        ext_pend_q <= 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_pend_q <= 1'b1;
      end else begin
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
        if (brk_pend_q) last_break <= shift_q;
      end
    end
  end

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign pop     = bus.rd_en & ~empty;
  assign do_push = push_req & (~full | pop);
  assign head    = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= {ext_pend_q, brk_pend_q, shift_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      hold_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop)     rptr_q <= rptr_q + (AW+1)'(1);
      if (push_req && full && !pop) overflow <= 1'b1;
      // Remember the current head so the outputs keep it once the FIFO drains.
      if (!empty) hold_q <= head;
    end
  end

  assign out_entry      = empty ? hold_q : head;
  assign bus.code_valid = ~empty;
  assign bus.code_ext   = out_entry[9];
  assign bus.code_break = out_entry[8];
  assign bus.code       = out_entry[7:0];
endmodule
